// File: rtl/rtc_read_cycle.sv
// rtc_read_cycle: read-transaction initiator for the RTC multiplexed AD bus.
//   clk_i, reset_i (async, active high) | start_i, addr_i request a read
//   bus_in_i pad value | bus_out_o, bus_oe_o bus drive | ad_o, rd_o, cs_o, wr_o strobes (active low)
//   data_out_o last byte read | busy_o transaction in flight | done_o one-cycle completion pulse
module rtc_read_cycle #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_AD    = 3,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_TURN  = 1,
  parameter int unsigned T_RD    = 4,
  parameter int unsigned T_RECOV = 2,
  parameter int unsigned CW      = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] bus_in_i,
  output logic [7:0] bus_out_o,
  output logic       bus_oe_o,
  output logic       ad_o,
  output logic       rd_o,
  output logic       cs_o,
  output logic       wr_o,
  output logic [7:0] data_out_o,
  output logic       busy_o,
  output logic       done_o
);
  typedef enum logic [2:0] {IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, TURN, READ, RECOV} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    addr_q, addr_d, bus_out_q, data_q;
  logic          oe_q, ad_q, rd_q, cs_q, busy_q, done_q, last, drive_d;
  assign last = cnt_q == '0;
  assign drive_d = state_d inside {ADDR_SETUP, ADDR_STROBE, ADDR_HOLD};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          state_d = ADDR_SETUP;
          cnt_d   = CW'(T_SETUP - 1);
          addr_d  = addr_i;
        end
      end
      ADDR_SETUP:  if (last) begin state_d = ADDR_STROBE; cnt_d = CW'(T_AD - 1);    end
      ADDR_STROBE: if (last) begin state_d = ADDR_HOLD;   cnt_d = CW'(T_HOLD - 1);  end
      ADDR_HOLD:   if (last) begin state_d = TURN;        cnt_d = CW'(T_TURN - 1);  end
      TURN:        if (last) begin state_d = READ;        cnt_d = CW'(T_RD - 1);    end
      READ:        if (last) begin state_d = RECOV;       cnt_d = CW'(T_RECOV - 1); end
      RECOV:       if (last) begin state_d = IDLE;        cnt_d = '0;               end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  // Outputs are decoded from the next state so they are registered yet line up with the state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= 8'h00;
      bus_out_q <= 8'h00;
      data_q    <= 8'h00;
      oe_q      <= 1'b0;
      ad_q      <= 1'b1;
      rd_q      <= 1'b1;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      bus_out_q <= drive_d ? addr_d : 8'h00;
      oe_q      <= drive_d;
      ad_q      <= state_d != ADDR_STROBE;
      rd_q      <= state_d != READ;
      cs_q      <= state_d == IDLE;
      busy_q    <= state_d != IDLE;
      done_q    <= state_q == RECOV && last;
      if (state_q == READ && last) data_q <= bus_in_i;
    end
  end
  assign bus_out_o  = bus_out_q;
  assign bus_oe_o   = oe_q;
  assign ad_o       = ad_q;
  assign rd_o       = rd_q;
  assign cs_o       = cs_q;
  assign wr_o       = 1'b1;
  assign data_out_o = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_rtc_read_cycle.sv
// tb_rtc_read_cycle: directed bench with a cycle-offset model of the RTC read transaction.
module tb_rtc_read_cycle;
  localparam int P1 = 2;
  localparam int P2 = P1 + 3;
  localparam int P3 = P2 + 2;
  localparam int P4 = P3 + 1;
  localparam int P5 = P4 + 4;
  localparam int S  = P5 + 2;
  logic clk, reset, start;
  logic [7:0] addr, bus_in, bus_out, data_out;
  logic bus_oe, ad, rd, cs, wr, busy, done;
  int total, bad, t;
  logic on;
  logic [7:0] ma, md;
  rtc_read_cycle dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .addr_i(addr), .bus_in_i(bus_in),
    .bus_out_o(bus_out), .bus_oe_o(bus_oe), .ad_o(ad), .rd_o(rd), .cs_o(cs), .wr_o(wr),
    .data_out_o(data_out), .busy_o(busy), .done_o(done)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  // t = cycles since the read was accepted (1..S in flight, S+1 is the done cycle, 0 idle)
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t  <= 0;
      md <= 8'h00;
    end else if (t == 0 || t == S + 1) begin
      t <= start ? 1 : 0;
      if (start) ma <= addr;
    end else begin
      if (t == P5) md <= bus_in;
      t <= t + 1;
    end
  end
  always @(negedge clk) begin
    if (on) begin
      automatic logic e_busy = t >= 1 && t <= S;
      automatic logic e_oe = t >= 1 && t <= P3;
      chk("busy", {7'b0, busy}, {7'b0, e_busy});
      chk("cs", {7'b0, cs}, {7'b0, !e_busy});
      chk("ad", {7'b0, ad}, {7'b0, !(t > P1 && t <= P2)});
      chk("rd", {7'b0, rd}, {7'b0, !(t > P4 && t <= P5)});
      chk("bus_oe", {7'b0, bus_oe}, {7'b0, e_oe});
      chk("bus_out", bus_out, e_oe ? ma : 8'h00);
      chk("done", {7'b0, done}, {7'b0, t == S + 1});
      chk("data_out", data_out, md);
      chk("inv_oe_rd", {7'b0, bus_oe & ~rd}, 8'h00);
      chk("inv_ad_cs", {7'b0, ~ad & (cs | ~bus_oe)}, 8'h00);
      chk("wr", {7'b0, wr}, 8'h01);
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    total = 0; bad = 0; on = 0;
    ma = 8'h00;
    reset = 1; start = 0; addr = 8'h00; bus_in = 8'h00;
    tick(1);
    on = 1;
    tick(1);
    reset = 0;
    tick(10);
    chk("rst_strobes", {4'b0, ad, rd, cs, wr}, 8'h0F);
    chk("rst_oe_busy_done", {5'b0, bus_oe, busy, done}, 8'h00);
    chk("rst_data", data_out, 8'h00);
    addr = 8'h0C; bus_in = 8'h5A; start = 1;
    tick(1);
    start = 0;
    chk("t2_c1_cs", {7'b0, cs}, 8'h00);
    tick(2);
    chk("t2_c3_ad", {7'b0, ad}, 8'h00);
    chk("t2_c3_bus", bus_out, 8'h0C);
    tick(2);
    chk("t2_c5_ad", {7'b0, ad}, 8'h00);
    start = 1; addr = 8'hEE;
    tick(1);
    start = 0;
    chk("t2_c6_ad", {7'b0, ad}, 8'h01);
    tick(3);
    chk("t2_c9_rd_oe", {6'b0, rd, bus_oe}, 8'h00);
    tick(3);
    chk("t2_c12_rd", {7'b0, rd}, 8'h00);
    tick(1);
    chk("t2_c13_rd_cs", {6'b0, rd, cs}, 8'h02);
    tick(2);
    chk("t2_c15_done", {5'b0, done, cs, busy}, 8'h06);
    chk("t2_data", data_out, 8'h5A);
    tick(1);
    chk("t2_no_extra", {6'b0, done, busy}, 8'h00);
    tick(2);
    addr = 8'h3C; bus_in = 8'h11; start = 1;
    tick(1);
    start = 0;
    tick(11);
    bus_in = 8'hA3;
    tick(3);
    chk("t3_data", data_out, 8'hA3);
    tick(2);
    addr = 8'h0A; bus_in = 8'h77; start = 1;
    tick(1);
    chk("t4_first_bus", bus_out, 8'h0A);
    addr = 8'h0B;
    tick(14);
    chk("t4_done1", {7'b0, done}, 8'h01);
    tick(1);
    chk("t4_second_bus", bus_out, 8'h0B);
    chk("t4_second_busy", {7'b0, busy}, 8'h01);
    tick(1);
    start = 0;
    tick(13);
    chk("t4_done2", {7'b0, done}, 8'h01);
    chk("t4_data", data_out, 8'h77);
    tick(5);
    addr = 8'h04; bus_in = 8'h99; start = 1;
    tick(1);
    start = 0;
    tick(9);
    chk("t5_in_read", {7'b0, rd}, 8'h00);
    reset = 1;
    #1;
    chk("t5_rst_strobes", {4'b0, ad, rd, cs, wr}, 8'h0F);
    chk("t5_rst_oe_busy", {5'b0, bus_oe, busy, done}, 8'h00);
    chk("t5_rst_data", data_out, 8'h00);
    tick(2);
    reset = 0;
    tick(20);
    addr = 8'h33; bus_in = 8'hC7; start = 1;
    tick(1);
    start = 0;
    tick(14);
    chk("t5_after_done", {7'b0, done}, 8'h01);
    chk("t5_after_data", data_out, 8'hC7);
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rtc_read_cycle.md
Name: rtc_read_cycle

Overview:
- Initiator for the read direction of the multiplexed address/data bus to the external RTC.
- On `start`, runs one complete read transaction: address phase (drive bus, pulse AD), bus turnaround, data phase (RD low, sample bus), recovery.
- Returns the sampled byte with a one-cycle `done` pulse.
- Sits beside the existing write-path bus mux. Its AD/RD/CS/WR and bus enable are merged into the RTC pins by the top-level arbiter; idle level of every strobe is 1.

Parameters:
- T_SETUP, 2, cycles bus holds address with CS low before AD asserts (min 1)
- T_AD, 3, cycles AD held low (min 1)
- T_HOLD, 2, cycles address held after AD deasserts (min 1)
- T_TURN, 1, cycles bus undriven before RD asserts (min 1)
- T_RD, 4, cycles RD held low; data sampled on the last (min 1)
- T_RECOV, 2, cycles CS held low after RD deasserts (min 1)
- CW, 4, phase counter width; every T_* must be ≤ 2^CW

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a read; sampled only in IDLE
- addr  in  8  RTC register address; captured when start accepted
- bus_in  in  8  RTC AD bus as seen from the pad
- bus_out  out  8  value driven onto the AD bus
- bus_oe  out  1  1 = drive bus_out onto the pad
- AD  out  1  address strobe, active low
- RD  out  1  read strobe, active low
- CS  out  1  chip select, active low
- WR  out  1  write strobe; constant 1 (this block never writes)
- data_out  out  8  last byte read; holds until the next read completes
- busy  out  1  1 in every state except IDLE
- done  out  1  one-cycle pulse, read complete

Behaviour:
- All outputs are registered. Reset, asynchronous to idle: state=IDLE, AD=RD=CS=WR=1, bus_oe=0, bus_out=8'h00, data_out=8'h00, busy=0, done=0, counter=0.
- FSM: IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, TURN, READ, RECOV.
- Each non-IDLE state lasts exactly its T_* cycles:
  - counter loads T_*-1 on state entry and decrements;
  - state advances when counter==0.
- IDLE:
  - strobes 1, bus_oe=0, busy=0;
  - start=1 at a rising edge captures addr and enters ADDR_SETUP.
- ADDR_SETUP: CS=0, AD=1, RD=1, bus_oe=1, bus_out=captured addr.
- ADDR_STROBE: as ADDR_SETUP but AD=0.
- ADDR_HOLD: AD=1, CS=0, bus_oe=1, bus_out=addr.
- TURN: bus_oe=0, bus_out=8'h00, CS=0, AD=RD=1.
- READ:
  - RD=0, CS=0, bus_oe=0;
  - on the edge ending the last READ cycle, data_out <= bus_in.
- RECOV: RD=1, CS=0, bus_oe=0.
- Leaving RECOV: state=IDLE, CS=1, done=1 for exactly that one cycle; busy=0 in that same cycle.
- Latency: start sampled at edge k, done high in the cycle after edge k+S, where S = T_SETUP+T_AD+T_HOLD+T_TURN+T_RD+T_RECOV (defaults S=14).
- Invariants:
  - bus_oe and RD=0 are never simultaneously true;
  - AD=0 only while CS=0 and bus_oe=1;
  - WR is always 1.
- Boundary cases:
  - start while busy is ignored, not queued;
  - start in the done cycle (state IDLE) is accepted, giving back-to-back reads with one idle cycle;
  - addr changes after acceptance have no effect;
  - reset mid-transaction forces idle outputs immediately, data_out clears to 0, and no done is produced.

Test Plan:
- Reset then idle 10 cycles → AD=RD=CS=WR=1, bus_oe=0, busy=0, done=0, data_out=00.
- start with addr=8'h0C, bus_in=8'h5A during READ → CS low 14 cycles, AD low cycles 3–5 with bus_out=0C, RD low cycles 9–12, done at cycle 15, data_out=5A.
- bus_in=8'h11 for the first 3 READ cycles and 8'hA3 on the 4th → data_out=A3 (last-cycle sampling).
- start held high continuously, addr=8'h0A then 8'h0B → two transactions, one IDLE cycle between them, second drives 0B; start pulses during busy create no extra transactions.
- Assert reset during READ of addr=8'h04 → strobes 1 and bus_oe=0 immediately, no done, data_out=00; a new read after reset completes normally.
- Every cycle of all tests → checker confirms never (bus_oe=1 && RD=0), never (AD=0 && CS=1), WR always 1.
